// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I opcode constants plus field encoders and request legality check
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SR  = 3'd5;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction

    function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_I) && ((f3 == F3_SLL) || (f3 == F3_SR));
    endfunction

    function automatic logic legal_req(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] imm);
        logic s12;
        logic s13;
        logic s21;
        logic ok;
        s12 = (imm[31:12] == {20{imm[11]}});
        s13 = (imm[31:13] == {19{imm[12]}});
        s21 = (imm[31:21] == {11{imm[20]}});
        ok  = 1'b0;
        case (op)
            OP_R:     ok = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            OP_I:     ok = is_shift(op, f3)
                           ? (((f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_SR))) && (imm[31:5] == 27'd0))
                           : s12;
            OP_LOAD:  ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7) && s12;
            OP_S:     ok = (f3 <= 3'd2) && s12;
            OP_B:     ok = (f3 != 3'd2) && (f3 != 3'd3) && !imm[0] && s13;
            OP_JAL:   ok = !imm[0] && s21;
            OP_JALR:  ok = (f3 == 3'd0) && s12;
            OP_LUI,
            OP_AUIPC: ok = (imm[11:0] == 12'd0);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode_req(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        logic [31:0] w;
        w = NOP_WORD;
        case (op)
            OP_R:              w = enc_r(f7, rs2, rs1, f3, rd, op);
            OP_I:              w = is_shift(op, f3) ? enc_r(f7, imm[4:0], rs1, f3, rd, op)
                                                    : enc_i(imm, rs1, f3, rd, op);
            OP_LOAD, OP_JALR:  w = enc_i(imm, rs1, f3, rd, op);
            OP_S:              w = enc_s(imm, rs2, rs1, f3, op);
            OP_B:              w = enc_b(imm, rs2, rs1, f3, op);
            OP_JAL:            w = enc_j(imm, rd, op);
            OP_LUI, OP_AUIPC:  w = enc_u(imm, rd, op);
            default:           w = NOP_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - instruction word FIFO; presents a NOP on the head when empty
module instr_fifo
    import rv_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO may still take a word when the head leaves on the same edge.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? W'(NOP_WORD) : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes field-level requests into RV32I words and queues them for fetch
module instr_encoder
    import rv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [6:0]                 req_op,
    input  logic [2:0]                 req_funct3,
    input  logic [6:0]                 req_funct7,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_rs1,
    input  logic [4:0]                 req_rs2,
    input  logic [31:0]                req_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_illegal,
    output logic [CNT_W-1:0]           illegal_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             r_stage_valid;
    logic             r_stage_legal;
    logic [31:0]      r_stage_word;
    logic             r_err_illegal;
    logic [CNT_W-1:0] r_illegal_count;
    logic [CW:0]      w_occupancy;
    logic             w_accept;
    logic             w_push;
    logic             w_reject;
    logic             w_full;
    logic             w_empty;

    // Space is reserved for the word still in the encode stage, so it never stalls.
    assign w_occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, r_stage_valid};
    assign req_ready   = !flush && (w_occupancy < (CW+1)'(DEPTH));
    assign w_accept    = req_valid && req_ready;
    assign w_push      = r_stage_valid && r_stage_legal && (!w_full || out_ready);
    assign w_reject    = r_stage_valid && !r_stage_legal && !flush;
    assign out_valid   = !w_empty;
    assign err_illegal   = r_err_illegal;
    assign illegal_count = r_illegal_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_valid   <= 1'b0;
            r_stage_legal   <= 1'b0;
            r_stage_word    <= NOP_WORD;
            r_err_illegal   <= 1'b0;
            r_illegal_count <= '0;
        end else begin
            r_stage_valid <= w_accept && !flush;
            if (w_accept) begin
                r_stage_legal <= legal_req(req_op, req_funct3, req_funct7, req_imm);
                r_stage_word  <= encode_req(req_op, req_funct3, req_funct7, req_rd,
                                            req_rs1, req_rs2, req_imm);
            end
            r_err_illegal <= w_reject;
            if (w_reject && (r_illegal_count != {CNT_W{1'b1}}))
                r_illegal_count <= r_illegal_count + CNT_W'(1);
        end
    end

    instr_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (r_stage_word),
        .i_pop   (out_ready),
        .o_data  (out_instr),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
